// File: rtl/controlador_display.sv
// Signed binary to BCD sequencer with time-multiplexed 7-segment scanning.
// Optional leading-zero blanking: define CONTROLADOR_DISPLAY_BLANCO_EN.
module controlador_display #(
  parameter int ANCHO_DATO   = 16,
  parameter int N_DIGITOS    = 4,
  parameter int DIV_REFRESCO = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [ANCHO_DATO-1:0] dato,
  input  logic                         valido,
  output logic                         ocupado,
  output logic                         listo,
  output logic [N_DIGITOS-1:0]         anodos,
  output logic [3:0]                   digito,
  output logic                         negativo,
  output logic                         desborde
);

  localparam int BW = 4 * N_DIGITOS;
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int CW = $clog2(DIV_REFRESCO);
  localparam int KW = $clog2(ANCHO_DATO + 1);

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    CONVIERTE = 2'd1,
    CARGA     = 2'd2
  } estado_t;

  estado_t               estado_r;
  logic [ANCHO_DATO-1:0] mag_r;
  logic [BW-1:0]         trabajo_r;
  logic [BW-1:0]         pantalla_r;
  logic                  signo_r;
  logic                  ovf_r;
  logic [KW-1:0]         bits_r;
  logic [CW-1:0]         cnt_r;
  logic [IW-1:0]         idx_r;

  logic [ANCHO_DATO-1:0] abs_s;
  logic [BW-1:0]         ajustado_s;
  logic [3:0]            dig_sel_s;
  logic                  blanco_s;

  // Shift-add-3 correction: every digit >= 5 gets +3 before the shift.
  function automatic logic [BW-1:0] suma3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Magnitude, correction and selected-digit datapath.
  always_comb begin
    abs_s      = dato[ANCHO_DATO-1] ? (~$unsigned(dato) + {{(ANCHO_DATO-1){1'b0}}, 1'b1})
                                    : $unsigned(dato);
    ajustado_s = suma3(trabajo_r);
    dig_sel_s  = 4'd0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      dig_sel_s = (IW'(i) == idx_r) ? pantalla_r[i*4 +: 4] : dig_sel_s;
    end
  end

`ifdef CONTROLADOR_DISPLAY_BLANCO_EN
  logic [IW-1:0] msd_s;

  // Highest non-zero digit; indices above it are blanked, index 0 never is.
  always_comb begin
    msd_s = {IW{1'b0}};
    for (int i = 0; i < N_DIGITOS; i++) begin
      msd_s = (pantalla_r[i*4 +: 4] != 4'd0) ? IW'(i) : msd_s;
    end
    blanco_s = (idx_r > msd_s);
  end
`else
  // All digits always lit.
  always_comb begin
    blanco_s = 1'b0;
  end
`endif

  // Conversion FSM with display latch and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_r   <= ESPERA;
      mag_r      <= {ANCHO_DATO{1'b0}};
      trabajo_r  <= {BW{1'b0}};
      pantalla_r <= {BW{1'b0}};
      signo_r    <= 1'b0;
      ovf_r      <= 1'b0;
      bits_r     <= {KW{1'b0}};
      ocupado    <= 1'b0;
      listo      <= 1'b0;
      negativo   <= 1'b0;
      desborde   <= 1'b0;
    end else begin
      case (estado_r)
        ESPERA: begin
          listo <= 1'b0;
          if (valido) begin
            mag_r     <= abs_s;
            signo_r   <= dato[ANCHO_DATO-1];
            trabajo_r <= {BW{1'b0}};
            ovf_r     <= 1'b0;
            bits_r    <= {KW{1'b0}};
            ocupado   <= 1'b1;
            estado_r  <= CONVIERTE;
          end
        end
        CONVIERTE: begin
          trabajo_r <= {ajustado_s[BW-2:0], mag_r[ANCHO_DATO-1]};
          mag_r     <= {mag_r[ANCHO_DATO-2:0], 1'b0};
          if (ajustado_s[BW-1]) begin
            ovf_r <= 1'b1;
          end
          bits_r <= bits_r + {{(KW-1){1'b0}}, 1'b1};
          if (bits_r == KW'(ANCHO_DATO - 1)) begin
            estado_r <= CARGA;
          end
        end
        CARGA: begin
          pantalla_r <= ovf_r ? {N_DIGITOS{4'h9}} : trabajo_r;
          negativo   <= signo_r;
          desborde   <= ovf_r;
          listo      <= 1'b1;
          ocupado    <= 1'b0;
          estado_r   <= ESPERA;
        end
        default: begin
          estado_r <= ESPERA;
          ocupado  <= 1'b0;
          listo    <= 1'b0;
        end
      endcase
    end
  end

  // Refresh divider, scan index and registered anode/digit outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r  <= {CW{1'b0}};
      idx_r  <= {IW{1'b0}};
      anodos <= {N_DIGITOS{1'b1}};
      digito <= 4'd0;
    end else begin
      if (cnt_r == CW'(DIV_REFRESCO - 1)) begin
        cnt_r <= {CW{1'b0}};
        idx_r <= (idx_r == IW'(N_DIGITOS - 1)) ? {IW{1'b0}} : idx_r + {{(IW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
      anodos <= blanco_s ? {N_DIGITOS{1'b1}} : ~(N_DIGITOS'(1) << idx_r);
      digito <= dig_sel_s;
    end
  end

endmodule

// File: tb/tb_controlador_display.sv
// Self-checking bench for controlador_display (ANCHO_DATO=16, N_DIGITOS=4, DIV_REFRESCO=4).
module tb_controlador_display;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valido = 1'b0;
  logic signed [15:0] dato = 16'sd0;
  logic               ocupado, listo, negativo, desborde;
  logic [3:0]         anodos, digito;

  typedef struct {
    logic signed [15:0] dato;
    logic [15:0]        bcd;
    logic               neg;
    logic               desb;
  } vec_t;

  vec_t exp_q[$];
  vec_t tabla[11];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  controlador_display #(.ANCHO_DATO(16), .N_DIGITOS(4), .DIV_REFRESCO(4)) dut (
    .clk(clk), .rst_n(rst_n), .dato(dato), .valido(valido), .ocupado(ocupado),
    .listo(listo), .anodos(anodos), .digito(digito), .negativo(negativo), .desborde(desborde)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Digits expected to have their anode driven for a given displayed value.
  function automatic logic [3:0] lit_mask(input logic [15:0] bcd);
    logic [3:0] m;
    m = 4'hF;
`ifdef CONTROLADOR_DISPLAY_BLANCO_EN
    m = 4'h1;
    for (int k = 1; k < 4; k++) begin
      if (bcd[k*4 +: 4] != 4'd0) m = 4'hF >> (3 - k);
    end
`endif
    return m;
  endfunction

  function automatic logic [15:0] nib_mask(input logic [3:0] m);
    return {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
  endfunction

  task automatic send(input vec_t v, input bit accept);
    dato   = v.dato;
    valido = 1'b1;
    tick();
    valido = 1'b0;
    if (accept) exp_q.push_back(v);
  endtask

  task automatic wait_listo(input int maxc, output int lat);
    lat = -1;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      if (listo === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic capture(output logic [15:0] seen, output logic [3:0] lit, output int multi);
    int z;
    seen  = 16'h0000;
    lit   = 4'h0;
    multi = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      z = 0;
      for (int k = 0; k < 4; k++) begin
        if (anodos[k] === 1'b0) begin
          z++;
          lit[k] = 1'b1;
          seen[k*4 +: 4] = digito;
        end
      end
      if (z > 1) multi++;
    end
  endtask

  task automatic check_result(input string tag, input int lat);
    vec_t        e;
    logic [15:0] seen;
    logic [3:0]  lit, m;
    int          multi;
    chk({tag, " latency"}, 32'(lat), 32'd17);
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " negativo"}, 32'(negativo), 32'(e.neg));
    chk({tag, " desborde"}, 32'(desborde), 32'(e.desb));
    capture(seen, lit, multi);
    chk({tag, " listo pulse"}, 32'(listo), 32'd0);
    m = lit_mask(e.bcd);
    chk({tag, " lit anodes"}, 32'(lit), 32'(m));
    chk({tag, " digits"}, 32'(seen & nib_mask(m)), 32'(e.bcd & nib_mask(m)));
    chk({tag, " one-hot"}, 32'(multi), 32'd0);
  endtask

  initial begin
    int          lat, cnt, multi;
    logic [3:0]  exp_an, lit;
    logic [15:0] seen;
    vec_t        v1234, v4321, v9999;

    tabla[0]  = '{16'sd1234,  16'h1234, 1'b0, 1'b0};
    tabla[1]  = '{-16'sd56,   16'h0056, 1'b1, 1'b0};
    tabla[2]  = '{16'sh8000,  16'h9999, 1'b1, 1'b1};
    tabla[3]  = '{16'sd9999,  16'h9999, 1'b0, 1'b0};
    tabla[4]  = '{16'sd0,     16'h0000, 1'b0, 1'b0};
    tabla[5]  = '{16'sd10000, 16'h9999, 1'b0, 1'b1};
    tabla[6]  = '{-16'sd1,    16'h0001, 1'b1, 1'b0};
    tabla[7]  = '{16'sd32767, 16'h9999, 1'b0, 1'b1};
    tabla[8]  = '{16'sd5,     16'h0005, 1'b0, 1'b0};
    tabla[9]  = '{-16'sd9999, 16'h9999, 1'b1, 1'b0};
    tabla[10] = '{16'sd100,   16'h0100, 1'b0, 1'b0};
    v1234 = tabla[0];
    v4321 = '{16'sd4321, 16'h4321, 1'b0, 1'b0};
    v9999 = tabla[3];

    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset anodos", 32'(anodos), 32'hF);
    chk("reset digito", 32'(digito), 32'd0);
    chk("reset ocupado", 32'(ocupado), 32'd0);
    chk("reset listo", 32'(listo), 32'd0);
    chk("reset negativo", 32'(negativo), 32'd0);
    chk("reset desborde", 32'(desborde), 32'd0);

    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_an = ~(4'b0001 << ((k - 1) / 4));
`ifdef CONTROLADOR_DISPLAY_BLANCO_EN
      if ((k - 1) / 4 > 0) exp_an = 4'hF;
`endif
      chk($sformatf("scan anodos step %0d", k), 32'(anodos), 32'(exp_an));
      chk($sformatf("scan digito step %0d", k), 32'(digito), 32'd0);
    end

    for (int i = 0; i < 11; i++) begin
      send(tabla[i], 1'b1);
      chk($sformatf("vec%0d ocupado", i), 32'(ocupado), 32'd1);
      wait_listo(40, lat);
      check_result($sformatf("vec%0d", i), lat);
    end

    // Second strobe while busy must be dropped.
    send(v1234, 1'b1);
    repeat (4) tick();
    chk("busy ocupado", 32'(ocupado), 32'd1);
    dato   = v4321.dato;
    valido = 1'b1;
    tick();
    valido = 1'b0;
    wait_listo(40, lat);
    check_result("busy", (lat < 0) ? lat : lat + 5);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (listo === 1'b1) cnt++;
    end
    chk("busy extra listo", 32'(cnt), 32'd0);

    // Reset in the middle of a conversion.
    send(v9999, 1'b0);
    repeat (7) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("midreset ocupado", 32'(ocupado), 32'd0);
    chk("midreset negativo", 32'(negativo), 32'd0);
    chk("midreset desborde", 32'(desborde), 32'd0);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (listo === 1'b1) cnt++;
    end
    chk("midreset listo", 32'(cnt), 32'd0);
    capture(seen, lit, multi);
    chk("midreset lit", 32'(lit), 32'(lit_mask(16'h0000)));
    chk("midreset digits", 32'(seen), 32'h0);
    send(v1234, 1'b1);
    wait_listo(40, lat);
    check_result("after reset", lat);

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
